// File: rtl/scram_sched_pkg.sv
// Shared constants and types for the scrambler-core scheduler and its arbiters.
package scram_sched_pkg;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // MPEG-TS packet length in bytes
    localparam int TS_PKT_LEN = 188;

    // Width of the saturating timeout-abort counter
    localparam int TO_CNT_W = 16;

endpackage

// File: rtl/scram_core_sched_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set request
// at or above ptr, wrapping from P_N-1 back to 0.
module rr_pick #(
    parameter int P_N = 4,
    parameter int P_W = 2
) (
    input  logic [P_N-1:0] req,
    input  logic [P_W-1:0] ptr,
    output logic [P_W-1:0] idx,
    output logic           vld
);

    // Scan the P_N candidates starting at ptr and latch the first hit
    always_comb begin
        int             c;
        logic [P_W-1:0] ci;
        idx = '0;
        vld = 1'b0;
        c   = 0;
        ci  = '0;
        for (int k = 0; k < P_N; k++) begin
            c = int'(ptr) + k;
            if (c >= P_N) c = c - P_N;
            ci = c[P_W-1:0];
            if (!vld && req[ci]) begin
                vld = 1'b1;
                idx = ci;
            end
        end
    end

endmodule

// File: rtl/scram_core_sched.sv
// Round-robin, packet-by-packet scheduler that time-shares one scrambler core
// among P_CH_NUM channel buffers and interlocks per-channel key writes.
module scram_core_sched
    import scram_sched_pkg::*;
#(
    parameter int P_CH_NUM  = 4,
    parameter int P_CH_W    = 2,
    parameter int P_TIMEOUT = 1024,
    parameter int P_TO_W    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [P_CH_NUM-1:0] pkt_rdy,
    input  logic [P_CH_NUM-1:0] key_upd_req,
    input  logic                core_end,
    output logic [P_CH_NUM-1:0] pkt_ack,
    output logic [P_CH_NUM-1:0] key_upd_gnt,
    output logic                core_start,
    output logic [P_CH_W-1:0]   core_sel,
    output logic                core_busy,
    output logic                to_err,
    output logic [TO_CNT_W-1:0] to_cnt
);

    localparam logic [P_TO_W-1:0]   TO_LAST = P_TO_W'(P_TIMEOUT - 1);
    localparam logic [P_CH_W-1:0]   CH_LAST = P_CH_W'(P_CH_NUM - 1);
    localparam logic [P_CH_NUM-1:0] CH_ONE  = P_CH_NUM'(1);

    sched_state_t        state;
    logic [P_CH_W-1:0]   ptr;
    logic [P_TO_W-1:0]   to_timer;
    logic [P_CH_NUM-1:0] elig;
    logic [P_CH_W-1:0]   pick_idx;
    logic                pick_vld;

    // A channel with a granted key write is held out of arbitration
    assign elig = pkt_rdy & ~key_upd_gnt;

    rr_pick #(
        .P_N (P_CH_NUM),
        .P_W (P_CH_W)
    ) u_rr_pick (
        .req (elig),
        .ptr (ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Scheduler FSM with registered strobes; core_busy spans START..DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            to_timer   <= '0;
            core_sel   <= '0;
            core_start <= 1'b0;
            core_busy  <= 1'b0;
            pkt_ack    <= '0;
            to_err     <= 1'b0;
            to_cnt     <= '0;
        end else begin
            core_start <= 1'b0;
            pkt_ack    <= '0;
            to_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        core_sel   <= pick_idx;
                        core_start <= 1'b1;
                        core_busy  <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    to_timer <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    // Completion wins over a timeout expiring in the same cycle
                    if (core_end) begin
                        pkt_ack <= CH_ONE << core_sel;
                        state   <= DONE;
                    end else if (to_timer == TO_LAST) begin
                        pkt_ack <= CH_ONE << core_sel;
                        to_err  <= 1'b1;
                        if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
                        state   <= DONE;
                    end else begin
                        to_timer <= to_timer + 1'b1;
                    end
                end
                DONE: begin
                    ptr       <= (core_sel == CH_LAST) ? '0 : core_sel + 1'b1;
                    core_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < P_CH_NUM; gi++) begin : g_key
            logic owned;
            logic sel_now;
            assign owned   = (state != IDLE) && (core_sel == P_CH_W'(gi));
            assign sel_now = (state == IDLE) && pick_vld && (pick_idx == P_CH_W'(gi));

            // Grant a key write only while the channel is outside the core;
            // a same-cycle selection defers the grant until the packet is done
            always_ff @(posedge clk) begin
                if (rst) begin
                    key_upd_gnt[gi] <= 1'b0;
                end else begin
                    key_upd_gnt[gi] <= key_upd_req[gi] &
                                       (key_upd_gnt[gi] | ~(owned | sel_now));
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_scram_core_sched.sv
// Bench for scram_core_sched: table of packet transactions, hand sequences for
// key interlock and mid-packet reset, and randomized round-robin traffic.
module tb_scram_core_sched;

    localparam int NCH     = 4;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pkt_rdy = '0;
    logic [3:0] key_upd_req = '0;
    logic       core_end = 1'b0;
    logic [3:0] pkt_ack;
    logic [3:0] key_upd_gnt;
    logic       core_start;
    logic [1:0] core_sel;
    logic       core_busy;
    logic       to_err;
    logic [15:0] to_cnt;

    int checks = 0;
    int errors = 0;
    int model_to_cnt = 0;

    scram_core_sched #(
        .P_CH_NUM  (NCH),
        .P_CH_W    (2),
        .P_TIMEOUT (TIMEOUT),
        .P_TO_W    (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_rdy     (pkt_rdy),
        .key_upd_req (key_upd_req),
        .core_end    (core_end),
        .pkt_ack     (pkt_ack),
        .key_upd_gnt (key_upd_gnt),
        .core_start  (core_start),
        .core_sel    (core_sel),
        .core_busy   (core_busy),
        .to_err      (to_err),
        .to_cnt      (to_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got hang required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pkt_rdy = '0;
        key_upd_req = '0;
        core_end = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_to_cnt = 0;
    endtask

    // One packet transaction: expects channel exp_ch to be granted; run_len is
    // the number of RUN cycles before core_end (<=0 means core_end never comes)
    task automatic do_pkt(input int exp_ch, input int run_len, input bit drop,
                          input bit chk_lat, input logic [3:0] req_in_run,
                          input string tag);
        int         waited = 0;
        int         k = 0;
        int         exp_run;
        int         early_acks = 0;
        bit         exp_err;
        bit         sel_ok = 1'b1;
        bit         gnt_ok = 1'b1;
        logic [3:0] ch_mask;
        ch_mask = 4'(1) << exp_ch;
        exp_err = (run_len <= 0) || (run_len > TIMEOUT);
        exp_run = exp_err ? TIMEOUT : run_len;
        while (core_start !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_start_seen"}, 32'(core_start), 32'd1);
        if (core_start !== 1'b1) return;
        if (chk_lat) chk({tag, "_start_latency"}, 32'(waited), 32'd1);
        chk({tag, "_sel"}, 32'(core_sel), 32'(exp_ch));
        chk({tag, "_busy_start"}, 32'(core_busy), 32'd1);
        if ((key_upd_gnt & ch_mask) != 0) gnt_ok = 1'b0;
        tick();
        key_upd_req = key_upd_req | req_in_run;
        while (k < TIMEOUT + 50) begin
            core_end = (run_len > 0) && (k == run_len - 1);
            if (core_sel !== 2'(exp_ch)) sel_ok = 1'b0;
            if ((key_upd_gnt & ch_mask) != 0) gnt_ok = 1'b0;
            if (pkt_ack != 0 || core_start) early_acks++;
            tick();
            core_end = 1'b0;
            k++;
            if (pkt_ack !== 4'b0000) break;
        end
        if (exp_err) model_to_cnt++;
        chk({tag, "_run_cycles"}, 32'(k), 32'(exp_run));
        chk({tag, "_ack"}, 32'(pkt_ack), 32'(ch_mask));
        chk({tag, "_to_err"}, 32'(to_err), 32'(exp_err));
        chk({tag, "_to_cnt"}, 32'(to_cnt), 32'(model_to_cnt));
        chk({tag, "_busy_done"}, 32'(core_busy), 32'd1);
        if (core_sel !== 2'(exp_ch)) sel_ok = 1'b0;
        if ((key_upd_gnt & ch_mask) != 0) gnt_ok = 1'b0;
        chk({tag, "_sel_stable"}, 32'(sel_ok), 32'd1);
        chk({tag, "_no_gnt_while_owned"}, 32'(gnt_ok), 32'd1);
        chk({tag, "_no_stray_strobe"}, 32'(early_acks), 32'd0);
        if (drop) pkt_rdy = pkt_rdy & ~ch_mask;
        tick();
        chk({tag, "_busy_idle"}, 32'(core_busy), 32'd0);
        chk({tag, "_ack_clear"}, 32'(pkt_ack), 32'd0);
        chk({tag, "_to_err_clear"}, 32'(to_err), 32'd0);
    endtask

    typedef struct {
        bit         rst_first;
        logic [3:0] rdy_or;
        int         run_len;
        bit         drop;
        int         exp_ch;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int         ptr_m;
        int         exp_ch;
        int         idle_bad;
        logic [3:0] rdy_m;

        vecs[0] = '{1'b1, 4'b0001, 200, 1'b1, 0};
        vecs[1] = '{1'b1, 4'b1111, scram_sched_pkg::TS_PKT_LEN + 2, 1'b0, 0};
        vecs[2] = '{1'b0, 4'b0000, scram_sched_pkg::TS_PKT_LEN + 2, 1'b0, 1};
        vecs[3] = '{1'b0, 4'b0000, scram_sched_pkg::TS_PKT_LEN + 2, 1'b0, 2};
        vecs[4] = '{1'b0, 4'b0000, scram_sched_pkg::TS_PKT_LEN + 2, 1'b0, 3};
        vecs[5] = '{1'b0, 4'b0000, scram_sched_pkg::TS_PKT_LEN + 2, 1'b0, 0};
        vecs[6] = '{1'b0, 4'b0000, 0, 1'b1, 1};
        vecs[7] = '{1'b0, 4'b0000, TIMEOUT, 1'b1, 2};
        vecs[8] = '{1'b0, 4'b0000, 7, 1'b1, 3};
        vecs[9] = '{1'b0, 4'b0000, 3, 1'b1, 0};

        do_reset();
        chk("reset_pkt_ack", 32'(pkt_ack), 32'd0);
        chk("reset_gnt", 32'(key_upd_gnt), 32'd0);
        chk("reset_core_start", 32'(core_start), 32'd0);
        chk("reset_core_sel", 32'(core_sel), 32'd0);
        chk("reset_core_busy", 32'(core_busy), 32'd0);
        chk("reset_to_err", 32'(to_err), 32'd0);
        chk("reset_to_cnt", 32'(to_cnt), 32'd0);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rst_first) do_reset();
            pkt_rdy = pkt_rdy | vecs[v].rdy_or;
            do_pkt(vecs[v].exp_ch, vecs[v].run_len, vecs[v].drop, 1'b1, 4'b0000,
                   $sformatf("vec%0d", v));
        end

        // Key interlock: request raised while channel 1 is in the core
        do_reset();
        pkt_rdy = 4'b0111;
        do_pkt(0, 10, 1'b0, 1'b1, 4'b0000, "key_a");
        do_pkt(1, 10, 1'b0, 1'b1, 4'b0010, "key_b");
        do_pkt(2, 10, 1'b0, 1'b1, 4'b0000, "key_c");
        chk("key_gnt_after_done", 32'(key_upd_gnt), 32'b0010);
        do_pkt(0, 10, 1'b0, 1'b1, 4'b0000, "key_d");
        do_pkt(2, 10, 1'b0, 1'b1, 4'b0000, "key_skip1");
        key_upd_req = 4'b0000;
        do_pkt(0, 10, 1'b0, 1'b1, 4'b0000, "key_e");
        chk("key_gnt_released", 32'(key_upd_gnt), 32'd0);
        do_pkt(1, 10, 1'b0, 1'b1, 4'b0000, "key_f");

        // Reset in the middle of channel 1's packet
        do_reset();
        pkt_rdy = 4'b0011;
        do_pkt(0, 10, 1'b1, 1'b1, 4'b0000, "mrst_a");
        tick();
        chk("mrst_start_ch1", 32'(core_start), 32'd1);
        chk("mrst_sel_ch1", 32'(core_sel), 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(core_busy), 32'd0);
        chk("mrst_sel", 32'(core_sel), 32'd0);
        chk("mrst_ack", 32'(pkt_ack), 32'd0);
        chk("mrst_start", 32'(core_start), 32'd0);
        chk("mrst_to_err", 32'(to_err), 32'd0);
        rst = 1'b0;
        model_to_cnt = 0;
        pkt_rdy = 4'b0101;
        do_pkt(0, 5, 1'b1, 1'b1, 4'b0000, "mrst_ptr0");
        do_pkt(2, 5, 1'b1, 1'b1, 4'b0000, "mrst_ch2");

        // Nothing ready: the core stays idle
        idle_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_busy !== 1'b0 || core_start !== 1'b0) idle_bad++;
        end
        chk("idle_when_no_request", 32'(idle_bad), 32'd0);

        // Randomized traffic against a transaction-level round-robin model
        do_reset();
        ptr_m = 0;
        rdy_m = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            rdy_m = rdy_m | 4'($urandom_range(0, 15));
            if (rdy_m == 4'b0000) rdy_m = 4'(1) << $urandom_range(0, 3);
            pkt_rdy = rdy_m;
            exp_ch = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (ptr_m + k) % NCH;
                if (exp_ch < 0 && ((rdy_m >> c) & 4'b0001) != 0) exp_ch = c;
            end
            do_pkt(exp_ch, int'($urandom_range(1, 12)), 1'b1, 1'b1, 4'b0000, "rnd");
            rdy_m = rdy_m & ~(4'(1) << exp_ch);
            ptr_m = (exp_ch + 1) % NCH;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
